uart_rx: RTL
============

Name: uart_rx

Overview:
- 16x-oversampling UART receiver. Sits directly downstream of the baud-rate generator and consumes its Rxclk_en tick as `clken`.
- Recovers 8N1 frames from the asynchronous `rx` pin and presents each byte on a ready/clear handshake to the bus-side register logic.
- Flags framing errors and overruns.

Parameters:
- DATA_BITS, 8, payload bits per frame, sent LSB first.
- OVERSAMPLE, 16, `clken` ticks per bit period. Must be a power of 2 and ≥ 4. MID = OVERSAMPLE/2.

Ports:
- clk_50m, in, 1, system clock.
- rstn, in, 1, synchronous active-low reset.
- clken, in, 1, oversample tick (Rxclk_en). 1-cycle pulse.
- rx, in, 1, asynchronous serial input. Idles high.
- rdy_clr, in, 1, consumer acknowledge. Clears `rdy` and `overrun`.
- data, out, DATA_BITS, last good received byte.
- rdy, out, 1, `data` valid and unread.
- framing_err, out, 1, last completed frame had a low stop bit.
- overrun, out, 1, a good frame completed while `rdy` was already 1.

Behaviour:
- Reset: when `rstn` is 0 at a clk_50m edge, all state is reset.
  - Synchronizer flops reset to 1. State goes to IDLE. Counters reset to 0.
  - `data`, `rdy`, `framing_err` and `overrun` all reset to 0.
  - Reset mid-frame abandons the frame. No output is updated from a partial frame.
- Synchronizer: 2-flop synchronizer on `rx`. `rx_s` is the second flop, so `rx_s` lags `rx` by 2 clk_50m cycles.
- All sampling uses `rx_s` and happens only in cycles where `clken` = 1. The FSM does not move in any other cycle.
- Counters: `scnt` is log2(OVERSAMPLE) bits; `bidx` is log2(DATA_BITS) bits.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on a tick with `rx_s` = 0, go to START with `scnt` ← 1.
  - START, on each tick:
    - if `rx_s` = 1, the start is false: go to IDLE with no output change;
    - else if `scnt` = MID-1, this is mid-start-bit: go to DATA with `scnt` ← 0 and `bidx` ← 0;
    - else `scnt` ← `scnt`+1.
  - DATA, on each tick:
    - if `scnt` = OVERSAMPLE-1, capture `shreg[bidx]` ← `rx_s` and set `scnt` ← 0. If `bidx` = DATA_BITS-1, go to STOP; else `bidx` ← `bidx`+1.
    - otherwise `scnt` ← `scnt`+1.
  - STOP, on each tick:
    - if `scnt` = OVERSAMPLE-1, sample the stop bit and go to IDLE with `scnt` ← 0;
    - otherwise `scnt` ← `scnt`+1.
- STOP-bit sample is 1 (good frame), in the same cycle:
  - `data` ← `shreg`, `rdy` ← 1, `framing_err` ← 0;
  - `overrun` ← 1 if `rdy` was 1 before this cycle. `data` is overwritten.
- STOP-bit sample is 0 (framing error):
  - `framing_err` ← 1;
  - `data`, `rdy` and `overrun` are unchanged.
  - FSM returns to IDLE and rearms on the next low tick. A break condition therefore produces a repeated framing error every frame time.
- `rdy_clr` = 1 clears `rdy` and `overrun` in the next cycle.
  - If a good frame completes in the same cycle, set wins: `rdy` = 1. `overrun` is set only if `rdy` was 1 before this cycle.
  - `rdy_clr` does not affect `framing_err`.
- Latency: `rdy` rises in the clk_50m cycle after the stop-bit mid-sample tick. That tick is nominally 9.5 bit periods after the falling edge, plus 2 cycles of synchronizer delay.
- Tolerance: bit centers are sampled at MID ± 1 tick, which gives about ±3% baud mismatch over 10 bits.
- No combinational path from `rx` or `rdy_clr` to any output.

Test Plan:
- The bench drives `clken` as a 1-cycle pulse every 4 clk_50m cycles, so one bit period is 64 cycles. Frames are 8N1 LSB first.
- Reset then send 0xA5 -> `rdy` = 1 and `data` = 0xA5 at stop-bit center; `framing_err` = 0; `overrun` = 0. Hold `rdy_clr` for 1 cycle -> `rdy` = 0.
- Drive `rx` low for 5 ticks, then high -> FSM returns to IDLE, `rdy` stays 0. A subsequent 0x3C frame is received correctly.
- Send 0x55 with stop bit forced 0 -> `framing_err` = 1, `rdy` = 0, `data` unchanged. A following good 0x0F frame -> `data` = 0x0F, `rdy` = 1, `framing_err` = 0.
- Send 0x11 then 0x22 without `rdy_clr` -> after the second frame `data` = 0x22, `rdy` = 1, `overrun` = 1. `rdy_clr` clears both.
- Assert `rdy_clr` in the exact cycle the second of two back-to-back frames completes -> `rdy` = 1, `overrun` = 0 if `rdy` was cleared earlier, else `overrun` = 1.
- Pull `rstn` low for 1 cycle in the middle of the DATA state of frame 0xFF -> all outputs 0 and state IDLE. A following 0x81 frame is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// 16x-oversampling 8N1 UART receiver: 2-flop rx synchronizer, start/data/stop FSM,
// ready/clear handshake with framing-error and overrun flags.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk_50m,
    input  logic                 rstn,
    input  logic                 clken,
    input  logic                 rx,
    input  logic                 rdy_clr,
    output logic [DATA_BITS-1:0] data,
    output logic                 rdy,
    output logic                 framing_err,
    output logic                 overrun
);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [SW-1:0] MID_M1 = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, rx_s_q;
    logic [SW-1:0]        scnt_q, scnt_d;
    logic [BW-1:0]        bidx_q, bidx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 rdy_q, rdy_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;

    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        bidx_d  = bidx_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        rdy_d   = rdy_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;

        if (rdy_clr) begin
            rdy_d = 1'b0;
            ovr_d = 1'b0;
        end

        if (clken) begin
            unique case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        state_d = START;
                        scnt_d  = SW'(1);
                    end
                end
                START: begin
                    if (rx_s_q) begin
                        state_d = IDLE;
                        scnt_d  = '0;
                    end else if (scnt_q == MID_M1) begin
                        state_d = DATA;
                        scnt_d  = '0;
                        bidx_d  = '0;
                    end else begin
                        scnt_d = scnt_q + SW'(1);
                    end
                end
                DATA: begin
                    if (scnt_q == S_LAST) begin
                        shreg_d[bidx_q] = rx_s_q;
                        scnt_d          = '0;
                        if (bidx_q == B_LAST) state_d = STOP;
                        else                  bidx_d  = bidx_q + BW'(1);
                    end else begin
                        scnt_d = scnt_q + SW'(1);
                    end
                end
                STOP: begin
                    if (scnt_q == S_LAST) begin
                        state_d = IDLE;
                        scnt_d  = '0;
                        // A completing good frame outranks a same-cycle rdy_clr.
                        if (rx_s_q) begin
                            data_d = shreg_q;
                            rdy_d  = 1'b1;
                            ferr_d = 1'b0;
                            if (rdy_q) ovr_d = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end else begin
                        scnt_d = scnt_q + SW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_50m) begin
        if (!rstn) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            state_q <= IDLE;
            scnt_q  <= '0;
            bidx_q  <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            rdy_q   <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync1_q <= rx;
            rx_s_q  <= sync1_q;
            state_q <= state_d;
            scnt_q  <= scnt_d;
            bidx_q  <= bidx_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            rdy_q   <= rdy_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data        = data_q;
    assign rdy         = rdy_q;
    assign framing_err = ferr_q;
    assign overrun     = ovr_q;
endmodule
